// File: rtl/maze_map_ctrl_if.sv
// rtl/maze_map_ctrl_if.sv - two-requester single-cell write port for the maze map controller
interface maze_map_ctrl_if;
   logic       i_Req0;
   logic [5:0] i_X0;
   logic [4:0] i_Y0;
   logic       i_Val0;
   logic       i_Req1;
   logic [5:0] i_X1;
   logic [4:0] i_Y1;
   logic       i_Val1;
   logic       o_Gnt0;
   logic       o_Gnt1;
   logic       o_Err;

   modport master (
      output i_Req0, i_X0, i_Y0, i_Val0,
      output i_Req1, i_X1, i_Y1, i_Val1,
      input  o_Gnt0, o_Gnt1, o_Err
   );

   modport slave (
      input  i_Req0, i_X0, i_Y0, i_Val0,
      input  i_Req1, i_X1, i_Y1, i_Val1,
      output o_Gnt0, o_Gnt1, o_Err
   );
endinterface

// File: rtl/maze_map_ctrl.sv
// rtl/maze_map_ctrl.sv - maze cell map owner: blank-gated round-robin writes and clear sweep
// Optional MAP_WRITE_ANYTIME_EN: ignore i_VBlank and keep the write window always open.
module maze_map_ctrl #(
   parameter int   COLS    = 40,
   parameter int   ROWS    = 30,
   parameter logic CLR_VAL = 1'b1
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst,
   input  logic [1:0]           i_MazeLevel,
   input  logic                 i_VBlank,
   input  logic                 i_Clear,
   maze_map_ctrl_if.slave       bus,
   output logic                 o_Busy,
   output logic [COLS*ROWS-1:0] o_MazeMap
);
   localparam int MAP_W = COLS * ROWS;
   localparam int IDX_W = $clog2(MAP_W);
   localparam int CTR_W = $clog2(ROWS);

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACK} state_t;

   state_t           state;
   logic [CTR_W-1:0] row_ctr;
   logic             rr_ptr;
   logic             clr_pend;

   logic             window;
   logic             any_req;
   logic             win1;
   logic [5:0]       sel_x;
   logic [4:0]       sel_y;
   logic             sel_val;
   logic [6:0]       lim_x;
   logic [5:0]       lim_y;
   logic             in_bounds;
   logic [IDX_W-1:0] cell_idx;
   logic [IDX_W-1:0] row_base;

`ifdef MAP_WRITE_ANYTIME_EN
   assign window = 1'b1;
`else
   assign window = i_VBlank;
`endif

   // A sole requester wins outright; the RR pointer only breaks ties.
   assign any_req = bus.i_Req0 | bus.i_Req1;
   assign win1    = bus.i_Req1 & (~bus.i_Req0 | rr_ptr);
   assign sel_x   = win1 ? bus.i_X1   : bus.i_X0;
   assign sel_y   = win1 ? bus.i_Y1   : bus.i_Y0;
   assign sel_val = win1 ? bus.i_Val1 : bus.i_Val0;

   always_comb begin
      lim_x = 7'(COLS);
      lim_y = 6'(ROWS);
      case (i_MazeLevel)
         2'b00:   begin lim_x = 7'd16; lim_y = 6'd12; end
         2'b01:   begin lim_x = 7'd32; lim_y = 6'd24; end
         default: begin lim_x = 7'(COLS); lim_y = 6'(ROWS); end
      endcase
   end

   assign in_bounds = ({1'b0, sel_x} < lim_x) && ({1'b0, sel_y} < lim_y) &&
                      ({1'b0, sel_x} < 7'(COLS)) && ({1'b0, sel_y} < 6'(ROWS));
   assign cell_idx  = IDX_W'(sel_y) * IDX_W'(COLS) + IDX_W'(sel_x);
   assign row_base  = IDX_W'(row_ctr) * IDX_W'(COLS);

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state      <= S_CLEAR;
         row_ctr    <= '0;
         rr_ptr     <= 1'b0;
         clr_pend   <= 1'b0;
         bus.o_Gnt0 <= 1'b0;
         bus.o_Gnt1 <= 1'b0;
         bus.o_Err  <= 1'b0;
         o_Busy     <= 1'b1;
         o_MazeMap  <= '0;
      end else begin
         bus.o_Gnt0 <= 1'b0;
         bus.o_Gnt1 <= 1'b0;
         bus.o_Err  <= 1'b0;
         // Busy trails the state by one edge so it drops on the first S_IDLE edge.
         o_Busy     <= (state == S_CLEAR);
         case (state)
            S_CLEAR: begin
               o_MazeMap[row_base +: COLS] <= {COLS{CLR_VAL}};
               if (i_Clear) begin
                  row_ctr <= '0;
               end else if (row_ctr == CTR_W'(ROWS - 1)) begin
                  row_ctr <= '0;
                  state   <= S_IDLE;
               end else begin
                  row_ctr <= row_ctr + 1'b1;
               end
            end
            S_IDLE: begin
               if (i_Clear || clr_pend) begin
                  clr_pend <= 1'b0;
                  row_ctr  <= '0;
                  state    <= S_CLEAR;
               end else if (window && any_req) begin
                  bus.o_Gnt0 <= ~win1;
                  bus.o_Gnt1 <= win1;
                  rr_ptr     <= ~win1;
                  if (in_bounds) o_MazeMap[cell_idx] <= sel_val;
                  else           bus.o_Err <= 1'b1;
                  state      <= S_ACK;
               end
            end
            S_ACK: begin
               if (i_Clear) clr_pend <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_maze_map_ctrl.sv
// tb/tb_maze_map_ctrl.sv - randomized scoreboard bench for maze_map_ctrl
module tb_maze_map_ctrl;
   localparam int COLS  = 40;
   localparam int ROWS  = 30;
   localparam int MAP_W = COLS * ROWS;
   localparam int LIM   = 200;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [1:0]       level;
   logic             vblank;
   logic             clear;
   logic             busy;
   logic [MAP_W-1:0] map;

   maze_map_ctrl_if ifc();

   maze_map_ctrl dut (
      .i_Clk       (clk),
      .i_Rst       (rst_n),
      .i_MazeLevel (level),
      .i_VBlank    (vblank),
      .i_Clear     (clear),
      .bus         (ifc),
      .o_Busy      (busy),
      .o_MazeMap   (map)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               id;
      bit               err;
      logic [MAP_W-1:0] map;
   } exp_t;

   exp_t             sb[$];
   logic [MAP_W-1:0] model_map;
   int               rr_m;
   int               n_chk = 0;
   int               n_fail = 0;
   int               cyc = 0;
   bit               dual_mode = 0;
   int               last_gnt_cyc = -1;
   int               dx[2][3];
   int               dy[2][3];
   bit               dv[2][3];

   always @(posedge clk) cyc++;

   function automatic void chk(string name, longint act, longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic void chk_map(string name, logic [MAP_W-1:0] act, logic [MAP_W-1:0] exp);
      int first;
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         first = -1;
         for (int i = MAP_W - 1; i >= 0; i--) if (act[i] !== exp[i]) first = i;
         $display("FAIL %s: first differing bit %0d got %b expected %b", name, first, act[first], exp[first]);
      end
   endfunction

   // Reference: a grant writes the addressed cell if it lies inside the level's playfield.
   function automatic void predict(int id, int x, int y, bit val, int lvl);
      exp_t e;
      int   lx;
      int   ly;
      bit   inb;
      lx  = (lvl == 0) ? 16 : (lvl == 1) ? 32 : 40;
      ly  = (lvl == 0) ? 12 : (lvl == 1) ? 24 : 30;
      inb = (x < lx) && (y < ly) && (x < COLS) && (y < ROWS);
      if (inb) model_map[y * COLS + x] = val;
      e.id  = id;
      e.err = !inb;
      e.map = model_map;
      sb.push_back(e);
      rr_m = 1 - id;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      int   who;
      if (rst_n && (ifc.o_Gnt0 || ifc.o_Gnt1)) begin
         who = ifc.o_Gnt1 ? 1 : 0;
         chk("gnt_onehot", longint'(ifc.o_Gnt0 & ifc.o_Gnt1), 0);
         if (sb.size() == 0) begin
            chk("unexpected_gnt", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("gnt_id", who, e.id);
            chk("gnt_err", longint'(ifc.o_Err), longint'(e.err));
            chk_map("map_after_gnt", map, e.map);
         end
         if (dual_mode && last_gnt_cyc >= 0) chk("gnt_spacing", cyc - last_gnt_cyc, 2);
         last_gnt_cyc = cyc;
      end else if (rst_n && ifc.o_Err) begin
         chk("err_without_gnt", 1, 0);
      end
   end

   task automatic drive(int id, bit req, int x, int y, bit val);
      if (id == 0) begin
         ifc.i_Req0 = req; ifc.i_X0 = 6'(x); ifc.i_Y0 = 5'(y); ifc.i_Val0 = val;
      end else begin
         ifc.i_Req1 = req; ifc.i_X1 = 6'(x); ifc.i_Y1 = 5'(y); ifc.i_Val1 = val;
      end
   endtask

   task automatic do_req(int id, int x, int y, bit val, output int lat);
      bit got;
      got = 0;
      lat = 0;
      drive(id, 1'b1, x, y, val);
      for (int i = 0; i < LIM && !got; i++) begin
         @(negedge clk);
         lat++;
         got = (id == 0) ? ifc.o_Gnt0 : ifc.o_Gnt1;
      end
      chk("grant_seen", got, 1);
      drive(id, 1'b0, x, y, val);
   endtask

   task automatic single(int id, int x, int y, bit val, int lvl, int exp_lat);
      int lat;
      @(negedge clk);
      level = 2'(lvl);
      predict(id, x, y, val, lvl);
      do_req(id, x, y, val, lat);
      chk("grant_latency", lat, exp_lat);
   endtask

   task automatic req_loop(int id);
      int lat;
      for (int k = 0; k < 3; k++) begin
         do_req(id, dx[id][k], dy[id][k], dv[id][k], lat);
         @(negedge clk);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int cnt;
      int lat;
      int first;
      bit seen;
      level = 2'd2; vblank = 1'b1; clear = 1'b0;
      drive(0, 1'b0, 0, 0, 1'b0);
      drive(1, 1'b0, 0, 0, 1'b0);

      // Reset state and power-up sweep.
      #12;
      chk_map("reset_map", map, '0);
      chk("reset_busy", longint'(busy), 1);
      chk("reset_gnt", longint'(ifc.o_Gnt0 | ifc.o_Gnt1), 0);
      chk("reset_err", longint'(ifc.o_Err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 1; i <= 31; i++) begin
         @(negedge clk);
         if (busy) cnt++;
         if (i == 29) chk("row29_before_last", longint'(map[MAP_W-1 -: COLS]), 0);
      end
      chk("busy_cycles_after_reset", cnt, 30);
      chk_map("map_all_ones", map, '1);
      model_map = '1;
      rr_m = 0;

      // Directed write, Hard level.
      single(0, 5, 2, 1'b0, 2, 1);
      chk("bit85", longint'(map[85]), 0);

      // Two held requesters alternate with one dead cycle between grants.
      level = 2'd2;
      for (int k = 0; k < 3; k++) begin
         for (int id = 0; id < 2; id++) begin
            dx[id][k] = $urandom_range(0, 45);
            dy[id][k] = $urandom_range(0, 31);
            dv[id][k] = 1'($urandom_range(0, 1));
         end
      end
      first = rr_m;
      for (int j = 0; j < 6; j++) begin
         int id;
         id = (j % 2 == 0) ? first : 1 - first;
         predict(id, dx[id][j/2], dy[id][j/2], dv[id][j/2], 2);
      end
      @(negedge clk);
      dual_mode = 1; last_gnt_cyc = -1;
      fork
         req_loop(0);
         req_loop(1);
      join
      dual_mode = 0;

      // Out-of-bounds for Easy: error pulse, map unchanged.
      single(1, 20, 3, 1'b0, 0, 1);

      // Window closed: request held without grant until VBlank rises.
      @(negedge clk);
      vblank = 1'b0;
      level = 2'd1;
      predict(0, 7, 9, 1'b0, 1);
      drive(0, 1'b1, 7, 9, 1'b0);
      cnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (ifc.o_Gnt0 || ifc.o_Gnt1) cnt++;
      end
      chk("no_gnt_while_closed", cnt, 0);
      vblank = 1'b1;
      do_req(0, 7, 9, 1'b0, lat);
      chk("latency_after_vblank", lat, 1);

      // Clear together with a request: sweep first, then the grant.
      @(negedge clk);
      level = 2'd2;
      clear = 1'b1;
      model_map = '1;
      predict(0, 39, 29, 1'b0, 2);
      fork
         begin @(negedge clk); clear = 1'b0; end
      join_none
      do_req(0, 39, 29, 1'b0, lat);
      chk("latency_after_clear", lat, 32);

      // Clear arriving in S_ACK is latched and served at the next S_IDLE.
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = busy;
      end
      chk("latched_clear_starts", seen, 1);
      cnt = 1;
      for (int i = 0; i < 100 && busy; i++) begin
         @(negedge clk);
         if (busy) cnt++;
      end
      chk("latched_clear_busy_cycles", cnt, 30);
      model_map = '1;
      chk_map("map_after_latched_clear", map, '1);

      // Random single writes across all levels, including out-of-range cells.
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         single($urandom_range(0, 1), $urandom_range(0, 47), $urandom_range(0, 31),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), 1);
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
